// File: rtl/scan_mem.sv
// Word memory with a CPU port and a serial program loader that fills all words MSB first.
// Optional serial readback of the old contents is enabled by defining SCAN_MEM_READBACK_EN.
module scan_mem #(
    parameter int unsigned DW = 8,
    parameter int unsigned AW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] data_in,
    input  logic          we,
    output logic [DW-1:0] data_out,
    input  logic          scan_en,
    input  logic          scan_in,
    output logic          scan_out,
    output logic          load_done
);

    localparam int unsigned DEPTH = 2 ** AW;
    localparam int unsigned CW    = 3;
    localparam int unsigned SW    = DW - 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [AW-1:0]   word_addr_q, word_addr_d;
    logic [SW-1:0]   shreg_q, shreg_d;
    logic            load_done_q, load_done_d;

    logic [DW-1:0]   mem_q [DEPTH];
    logic            mem_we_c;
    logic [AW-1:0]   mem_waddr_c;
    logic [DW-1:0]   mem_wdata_c;

    // Loader next state and the single memory write port shared by CPU and loader
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        word_addr_d = word_addr_q;
        shreg_d     = shreg_q;
        load_done_d = load_done_q;
        mem_we_c    = 1'b0;
        mem_waddr_c = addr;
        mem_wdata_c = data_in;

        if (!scan_en) begin
            state_d     = IDLE;
            bit_cnt_d   = '0;
            word_addr_d = '0;
            shreg_d     = '0;
            mem_we_c    = we;
        end else if (state_q != DONE) begin
            shreg_d   = SW'({shreg_q, scan_in});
            bit_cnt_d = bit_cnt_q + CW'(1);
            if (state_q == IDLE) begin
                state_d     = SHIFT;
                load_done_d = 1'b0;
            end
            if (bit_cnt_q == CW'(DW - 1)) begin
                mem_we_c    = 1'b1;
                mem_waddr_c = word_addr_q;
                mem_wdata_c = {shreg_q, scan_in};
                bit_cnt_d   = '0;
                word_addr_d = word_addr_q + AW'(1);
                if (word_addr_q == AW'(DEPTH - 1)) begin
                    state_d     = DONE;
                    load_done_d = 1'b1;
                end
            end
        end

        // Reset wins over any write on the same edge
        if (!rst_n) begin
            mem_we_c = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            word_addr_q <= '0;
            shreg_q     <= '0;
            load_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            word_addr_q <= word_addr_d;
            shreg_q     <= shreg_d;
            load_done_q <= load_done_d;
        end
    end

    // Array contents survive reset
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            mem_q[mem_waddr_c] <= mem_wdata_c;
        end
    end

    assign data_out  = scan_en ? '0 : mem_q[addr];
    assign load_done = load_done_q;

`ifdef SCAN_MEM_READBACK_EN
    localparam int unsigned BIW = (DW > 1) ? $clog2(DW) : 1;

    logic [BIW-1:0] rb_idx_c;

    // Bit about to be replaced by the loader, presented before the word is overwritten
    assign rb_idx_c = BIW'(DW - 1) - BIW'(bit_cnt_q);
    assign scan_out = (scan_en && (state_q != DONE)) ? mem_q[word_addr_q][rb_idx_c] : 1'b0;
`else
    assign scan_out = 1'b0;
`endif

endmodule

// File: doc/scan_mem.md
SCAN_MEM -- requirements
Module: scan_mem

Interface
REQ-001 Parameter DW, default 8: memory word width, equal to the CPU data bus width.
REQ-002 Parameter AW, default 4: address width; depth is 2**AW words, equal to the CPU address bus width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 addr  input  AW  CPU word address.
REQ-006 data_in  input  DW  CPU write data, fed from the CPU data_out.
REQ-007 we  input  1  CPU write enable.
REQ-008 data_out  output  DW  CPU read data, fed to the CPU data_in.
REQ-009 scan_en  input  1  serial program load mode; the CPU port is locked out while high.
REQ-010 scan_in  input  1  serial load data, MSB first, word 0 first.
REQ-011 scan_out  output  1  serial readback of the old memory contents.
REQ-012 load_done  output  1  high once all 2**AW words have been loaded.

Function
REQ-013 Storage SHALL be a 2**AW x DW array; reset SHALL NOT alter array contents.
REQ-014 CPU write: scan_en=0 and we=1 SHALL write mem[addr] <= data_in at the clock edge.
REQ-015 CPU write: scan_en=1 SHALL block the write regardless of we.
REQ-016 data_out SHALL be combinational mem[addr] while scan_en=0, and all-zero while scan_en=1.
REQ-017 Loader FSM states SHALL be IDLE, SHIFT and DONE, with registers bit_cnt (3b), word_addr (AW b), shreg (DW-1 b) and load_done.
REQ-018 In IDLE or SHIFT, each edge with scan_en=1 SHALL perform shreg <= {shreg, scan_in} and bit_cnt+1; the first such edge in IDLE SHALL move the FSM to SHIFT.
REQ-019 On an edge with bit_cnt==DW-1 and scan_en=1, the loader SHALL write mem[word_addr] <= {shreg, scan_in}, set bit_cnt to 0 and increment word_addr.
REQ-020 If that edge also has word_addr==2**AW-1, the FSM SHALL enter DONE, set load_done=1 and wrap word_addr to 0.
REQ-021 In DONE, scan_in SHALL be ignored and the state held while scan_en=1.
REQ-022 From any state, an edge with scan_en=0 SHALL return the FSM to IDLE, clear bit_cnt and word_addr, and discard any partial word.
REQ-023 load_done SHALL hold its value through the return to IDLE and clear on the IDLE->SHIFT transition.
REQ-024 Full-load latency: load_done SHALL be visible after exactly DW*2**AW edges with scan_en=1 (128 at default parameters).

Reset
REQ-025 An edge with rst_n=0 SHALL force state=IDLE, bit_cnt=0, word_addr=0, shreg=0 and load_done=0.
REQ-026 After reset, data_out SHALL equal mem[addr] and scan_out SHALL be 0 (while scan_en=0).
REQ-027 rst_n=0 SHALL override scan_en and we; a write that would occur on the same edge SHALL NOT happen.
REQ-028 On reset mid-scan, words completed before the reset SHALL be retained and the partial word discarded.

Configuration
REQ-029 Macro SCAN_MEM_READBACK_EN defined: scan_out SHALL equal mem[word_addr][DW-1-bit_cnt] while scan_en=1 and state!=DONE, and 0 otherwise.
REQ-030 With SCAN_MEM_READBACK_EN defined, each bit SHALL be presented before that word is overwritten.
REQ-031 Macro SCAN_MEM_READBACK_EN undefined: scan_out SHALL be tied to constant 0 and no readback mux logic SHALL be present; all other behaviour is unchanged.

Verification
REQ-032 CPU write/read: scan_en=0, we=1, addr=3, data_in=0xA5 for one edge, then we=0 -> data_out=0xA5 while addr=3.
REQ-033 Full load: scan_en=1 for 128 edges, shifting bytes 0x10+i MSB first -> load_done=1 after edge 128; with scan_en=0, mem[i] reads 0x10+i for i=0..15.
REQ-034 Readback (SCAN_MEM_READBACK_EN): CPU writes mem[0]=0xC3, then scan_en=1 -> scan_out over the first 8 cycles = 1,1,0,0,0,0,1,1.
REQ-035 Abort: scan_en=1 for 12 edges of 0xFF bits, then scan_en=0 -> mem[0]=0xFF, mem[1] unchanged; re-entry loads word 0 again.
REQ-036 Reset mid-scan: rst_n=0 after 20 bits -> load_done=0, mem[0..1] hold the new values, mem[2] unchanged, next scan starts at word 0.
REQ-037 Lockout: scan_en=1, we=1, addr=5, data_in=0x3C -> mem[5] unchanged and data_out=0x00 throughout.
